mac_seq_ctrl: RTL and testbench
===============================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of operand-count input and internal counter.
REQ-002 SHALL have port clk  input  1: clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1: reset; asynchronous, active-high.
REQ-004 SHALL have port start  input  1: request to begin one accumulation job; sampled only in IDLE.
REQ-005 SHALL have port len  input  CNT_W: number of operand pairs in the job; sampled with start.
REQ-006 SHALL have port abort  input  1: synchronous job cancel.
REQ-007 SHALL have port in_valid  input  1: upstream operand pair available.
REQ-008 SHALL have port in_ready  output  1: controller accepts an operand pair this cycle.
REQ-009 SHALL have port ld_in  output  1: load strobe for the operand input registers.
REQ-010 SHALL have port acc_clr  output  1: clear strobe for the accumulator.
REQ-011 SHALL have port acc_en  output  1: accumulate-enable for the accumulator.
REQ-012 SHALL have port ld_out  output  1: load strobe for the 12-bit output register.
REQ-013 SHALL have port busy  output  1: high in every state except IDLE.
REQ-014 SHALL have port done  output  1: one-cycle job-complete pulse.
REQ-015 SHALL have port remaining  output  CNT_W: operand pairs still to be accepted in the current job.

Function
REQ-016 SHALL implement FSM states IDLE, CLR, ACCUM, DRAIN, LOAD, DONE.
REQ-017 IDLE: start=1 -> CLR, latch len into remaining; start=0 -> stay.
REQ-018 CLR: acc_clr=1 for exactly one cycle; next state ACCUM if remaining!=0, else LOAD.
REQ-019 ACCUM: in_ready=1; ld_in = in_valid & in_ready (combinational); each ld_in decrements remaining by 1.
REQ-020 ACCUM: ld_in with remaining==1 -> DRAIN next cycle (remaining becomes 0); otherwise stay in ACCUM, idle cycles with in_valid=0 allowed indefinitely.
REQ-021 acc_en SHALL be ld_in delayed by one clock (registered), so each accepted pair is accumulated the cycle after capture.
REQ-022 DRAIN: one cycle, in_ready=0, acc_en=1 for the final pair; next state LOAD.
REQ-023 LOAD: ld_out=1 for exactly one cycle; next state DONE.
REQ-024 DONE: done=1 for exactly one cycle; next state IDLE; busy=0 from the following cycle.
REQ-025 Latency: start sampled at edge 0 with len=N, in_valid held 1 -> ld_in on cycles 2..N+1, ld_out on cycle N+3, done on cycle N+4.
REQ-026 len=0: CLR -> LOAD -> DONE; output register loaded with cleared accumulator (zero); no ld_in or acc_en.
REQ-027 start while busy=1 SHALL be ignored; len changes while busy SHALL NOT affect the job.
REQ-028 abort=1 in any non-IDLE state -> IDLE next cycle; no ld_out or done issued; remaining cleared to 0; pending registered acc_en cleared.
REQ-029 abort has priority over every other transition including the final ld_in in ACCUM; in_ready SHALL be 0 during an abort cycle.
REQ-030 in_ready, acc_clr, ld_out, done, busy SHALL be Moore outputs decoded from state; no glitching dependence on inputs except ld_in.
REQ-031 remaining SHALL never underflow; decrement only on ld_in.
REQ-032 ld_out and acc_en SHALL never be asserted in the same cycle; acc_clr and acc_en likewise.

Reset
REQ-033 rst=1 SHALL force state IDLE, remaining=0, registered acc_en=0 immediately, regardless of clk.
REQ-034 During and after reset all outputs SHALL be 0 (in_ready, ld_in, acc_clr, acc_en, ld_out, busy, done, remaining).
REQ-035 Reset asserted mid-job SHALL discard the job; first start after reset release begins a fresh job.

Verification
REQ-036 start, len=3, in_valid=1 continuous -> acc_clr cycle 1, ld_in cycles 2-4, acc_en cycles 3-5, ld_out cycle 6, done cycle 7, remaining 3,2,1,0.
REQ-037 len=4, in_valid toggling 1,0,1,0,... -> exactly 4 ld_in pulses, remaining decrements only on those, single ld_out and done.
REQ-038 len=0 -> acc_clr, ld_out, done on consecutive cycles 1-3; zero ld_in/acc_en pulses.
REQ-039 abort after 2 of len=5 accepted -> IDLE next cycle, busy=0, remaining=0, no ld_out, no done; next start len=1 completes normally.
REQ-040 start pulses during a len=3 job and rst asserted mid-ACCUM -> extra starts ignored; rst clears all outputs asynchronously and job never completes.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Sequencing controller for a multiply-accumulate datapath: clears the accumulator,
// accepts len operand pairs, drains the last product, then loads the output register.
module mac_seq_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ld_in,
   output logic             acc_clr,
   output logic             acc_en,
   output logic             ld_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] remaining
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CLR   = 3'd1;
   localparam logic [2:0] ACCUM = 3'd2;
   localparam logic [2:0] DRAIN = 3'd3;
   localparam logic [2:0] LOAD  = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             acc_en_q, acc_en_d;

   // in_ready is dropped during an abort so no pair is captured on a cancelled job
   assign in_ready  = (state_q == ACCUM) && !abort;
   assign ld_in     = in_valid && in_ready;
   assign acc_clr   = (state_q == CLR);
   assign ld_out    = (state_q == LOAD);
   assign done      = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign acc_en    = acc_en_q;
   assign remaining = remaining_q;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      acc_en_d    = ld_in;
      if (abort && (state_q != IDLE)) begin
         state_d     = IDLE;
         remaining_d = '0;
         acc_en_d    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_d     = CLR;
                  remaining_d = len;
               end
            end
            CLR: begin
               state_d = (remaining_q != '0) ? ACCUM : LOAD;
            end
            ACCUM: begin
               if (ld_in && (remaining_q != '0)) begin
                  remaining_d = remaining_q - CNT_W'(1);
                  if (remaining_q == CNT_W'(1)) begin
                     state_d = DRAIN;
                  end
               end
            end
            DRAIN:   state_d = LOAD;
            LOAD:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         acc_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         acc_en_q    <= acc_en_d;
      end
   end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: one table row per clock cycle, each row drives
// the inputs and checks the status outputs and remaining count against hand values.
module tb_mac_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] len;
   logic       abort;
   logic       in_valid;
   logic       in_ready, ld_in, acc_clr, acc_en, ld_out, busy, done;
   logic [7:0] remaining;

   int n_checks = 0;
   int n_pass   = 0;
   int row_idx  = 0;

   mac_seq_ctrl #(.CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .abort     (abort),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ld_in     (ld_in),
      .acc_clr   (acc_clr),
      .acc_en    (acc_en),
      .ld_out    (ld_out),
      .busy      (busy),
      .done      (done),
      .remaining (remaining)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   // status bit order: {in_ready, ld_in, acc_clr, acc_en, ld_out, busy, done}
   function automatic logic [6:0] status();
      return {in_ready, ld_in, acc_clr, acc_en, ld_out, busy, done};
   endfunction

   task automatic row(input logic st, input logic [7:0] ln, input logic iv, input logic ab,
                      input logic [6:0] exp_stat, input logic [7:0] exp_rem);
      @(posedge clk);
      #1;
      start    = st;
      len      = ln;
      in_valid = iv;
      abort    = ab;
      #1;
      chk($sformatf("r%0d_stat", row_idx), {9'd0, status()}, {9'd0, exp_stat});
      chk($sformatf("r%0d_rem", row_idx), {8'd0, remaining}, {8'd0, exp_rem});
      $display("row %0d: start=%b len=%0d iv=%b abort=%b stat=%b rem=%0d",
               row_idx, st, ln, iv, ab, status(), remaining);
      row_idx++;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = 8'd0; abort = 1'b0; in_valid = 1'b0;
      #2;
      chk("reset_stat", {9'd0, status()}, 16'd0);
      chk("reset_rem", {8'd0, remaining}, 16'd0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;

      // len=3, in_valid held high
      row(1, 8'd3, 1, 0, 7'b0000000, 8'd0);
      row(0, 8'd3, 1, 0, 7'b0010010, 8'd3);
      row(0, 8'd0, 1, 0, 7'b1100010, 8'd3);
      row(0, 8'd0, 1, 0, 7'b1101010, 8'd2);
      row(0, 8'd0, 1, 0, 7'b1101010, 8'd1);
      row(0, 8'd0, 1, 0, 7'b0001010, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0000110, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0000011, 8'd0);
      row(0, 8'd0, 0, 0, 7'b0000000, 8'd0);

      // len=4, in_valid toggling
      row(1, 8'd4, 0, 0, 7'b0000000, 8'd0);
      row(0, 8'd4, 0, 0, 7'b0010010, 8'd4);
      row(0, 8'd0, 1, 0, 7'b1100010, 8'd4);
      row(0, 8'd0, 0, 0, 7'b1001010, 8'd3);
      row(0, 8'd0, 1, 0, 7'b1100010, 8'd3);
      row(0, 8'd0, 0, 0, 7'b1001010, 8'd2);
      row(0, 8'd0, 1, 0, 7'b1100010, 8'd2);
      row(0, 8'd0, 0, 0, 7'b1001010, 8'd1);
      row(0, 8'd0, 1, 0, 7'b1100010, 8'd1);
      row(0, 8'd0, 0, 0, 7'b0001010, 8'd0);
      row(0, 8'd0, 0, 0, 7'b0000110, 8'd0);
      row(0, 8'd0, 0, 0, 7'b0000011, 8'd0);
      row(0, 8'd0, 0, 0, 7'b0000000, 8'd0);

      // len=0: clear, load, done back to back
      row(1, 8'd0, 1, 0, 7'b0000000, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0010010, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0000110, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0000011, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0000000, 8'd0);

      // len=5 aborted after two pairs, then a normal len=1 job
      row(1, 8'd5, 1, 0, 7'b0000000, 8'd0);
      row(0, 8'd5, 1, 0, 7'b0010010, 8'd5);
      row(0, 8'd0, 1, 0, 7'b1100010, 8'd5);
      row(0, 8'd0, 1, 0, 7'b1101010, 8'd4);
      row(0, 8'd0, 1, 1, 7'b0001010, 8'd3);
      row(0, 8'd0, 1, 0, 7'b0000000, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0000000, 8'd0);
      row(1, 8'd1, 1, 0, 7'b0000000, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0010010, 8'd1);
      row(0, 8'd0, 1, 0, 7'b1100010, 8'd1);
      row(0, 8'd0, 1, 0, 7'b0001010, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0000110, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0000011, 8'd0);
      row(0, 8'd0, 0, 0, 7'b0000000, 8'd0);

      // abort beats the final ld_in of a len=1 job
      row(1, 8'd1, 1, 0, 7'b0000000, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0010010, 8'd1);
      row(0, 8'd0, 1, 1, 7'b0000010, 8'd1);
      row(0, 8'd0, 1, 0, 7'b0000000, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0000000, 8'd0);

      // len=3 with repeated start/len changes while busy, then async reset mid-ACCUM
      row(1, 8'd3, 1, 0, 7'b0000000, 8'd0);
      row(1, 8'd7, 1, 0, 7'b0010010, 8'd3);
      row(1, 8'd7, 1, 0, 7'b1100010, 8'd3);
      row(1, 8'd7, 1, 0, 7'b1101010, 8'd2);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_stat", {9'd0, status()}, 16'd0);
      chk("async_rst_rem", {8'd0, remaining}, 16'd0);
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("hold_rst_stat", {9'd0, status()}, 16'd0);
      chk("hold_rst_rem", {8'd0, remaining}, 16'd0);
      #2 rst = 1'b0;
      row(0, 8'd0, 1, 0, 7'b0000000, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0000000, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0000000, 8'd0);

      // fresh len=2 job after reset
      row(1, 8'd2, 1, 0, 7'b0000000, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0010010, 8'd2);
      row(0, 8'd0, 1, 0, 7'b1100010, 8'd2);
      row(0, 8'd0, 1, 0, 7'b1101010, 8'd1);
      row(0, 8'd0, 1, 0, 7'b0001010, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0000110, 8'd0);
      row(0, 8'd0, 1, 0, 7'b0000011, 8'd0);
      row(0, 8'd0, 0, 0, 7'b0000000, 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
